// File: rtl/instr_fetch.sv
// Instruction fetch stage: 256x16 program memory with a three-state fetch FSM,
// a one-deep pending-address register and sticky overrun/halt flags.
module instr_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  pc,
   input  logic        pc_strobe,
   input  logic        prog_we,
   input  logic [7:0]  prog_addr,
   input  logic [15:0] prog_wdata,
   input  logic        instr_ready,
   input  logic        clear_overrun,
   output logic [15:0] instr,
   output logic [7:0]  instr_addr,
   output logic        instr_valid,
   output logic        busy,
   output logic        overrun,
   output logic        halt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } state_t;

   logic [15:0] mem_q [256];

   state_t      state_q,       state_d;
   logic [7:0]  fetch_addr_q,  fetch_addr_d;
   logic [7:0]  pend_addr_q,   pend_addr_d;
   logic        pend_vld_q,    pend_vld_d;
   logic [15:0] instr_q,       instr_d;
   logic [7:0]  instr_addr_q,  instr_addr_d;
   logic        instr_valid_q, instr_valid_d;
   logic        overrun_q,     overrun_d;
   logic        halt_q,        halt_d;

   logic xfer;
   logic halt_hit;
   logic ovr_set;

   // Program memory write port is independent of reset so loads always land.
   always_ff @(posedge clk) begin
      if (prog_we) begin
         mem_q[prog_addr] <= prog_wdata;
      end
   end

   assign xfer     = instr_valid_q & instr_ready;
   assign halt_hit = xfer & (instr_q[15:12] == 4'hF);

   always_comb begin
      state_d       = state_q;
      fetch_addr_d  = fetch_addr_q;
      pend_addr_d   = pend_addr_q;
      pend_vld_d    = pend_vld_q;
      instr_d       = instr_q;
      instr_addr_d  = instr_addr_q;
      instr_valid_d = instr_valid_q;
      ovr_set       = 1'b0;

      case (state_q)
         IDLE: begin
            if (pc_strobe) begin
               if (halt_q) begin
                  ovr_set = 1'b1;
               end else begin
                  fetch_addr_d = pc;
                  state_d      = READ;
               end
            end
         end

         READ: begin
            // Sampling the array before this edge's write gives read-before-write.
            instr_d       = mem_q[fetch_addr_q];
            instr_addr_d  = fetch_addr_q;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
            if (pc_strobe) begin
               ovr_set     = pend_vld_q;
               pend_addr_d = pc;
               pend_vld_d  = 1'b1;
            end
         end

         HOLD: begin
            if (xfer) begin
               instr_valid_d = 1'b0;
               if (halt_q || halt_hit) begin
                  // Halting transfer: everything queued behind it is dropped.
                  ovr_set    = pc_strobe | pend_vld_q;
                  pend_vld_d = 1'b0;
                  state_d    = IDLE;
               end else if (pc_strobe) begin
                  ovr_set      = pend_vld_q;
                  fetch_addr_d = pc;
                  pend_vld_d   = 1'b0;
                  state_d      = READ;
               end else if (pend_vld_q) begin
                  fetch_addr_d = pend_addr_q;
                  pend_vld_d   = 1'b0;
                  state_d      = READ;
               end else begin
                  state_d = IDLE;
               end
            end else if (pc_strobe) begin
               ovr_set     = pend_vld_q;
               pend_addr_d = pc;
               pend_vld_d  = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      halt_d    = halt_q | halt_hit;
      overrun_d = ovr_set | (overrun_q & ~clear_overrun);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         fetch_addr_q  <= 8'h00;
         pend_addr_q   <= 8'h00;
         pend_vld_q    <= 1'b0;
         instr_q       <= 16'h0000;
         instr_addr_q  <= 8'h00;
         instr_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
         halt_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_addr_q  <= fetch_addr_d;
         pend_addr_q   <= pend_addr_d;
         pend_vld_q    <= pend_vld_d;
         instr_q       <= instr_d;
         instr_addr_q  <= instr_addr_d;
         instr_valid_q <= instr_valid_d;
         overrun_q     <= overrun_d;
         halt_q        <= halt_d;
      end
   end

   assign instr       = instr_q;
   assign instr_addr  = instr_addr_q;
   assign instr_valid = instr_valid_q;
   assign overrun     = overrun_q;
   assign halt        = halt_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; inputs change and outputs are
// sampled 1ns after each rising edge.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pc;
   logic        pc_strobe;
   logic        prog_we;
   logic [7:0]  prog_addr;
   logic [15:0] prog_wdata;
   logic        instr_ready;
   logic        clear_overrun;
   logic [15:0] instr;
   logic [7:0]  instr_addr;
   logic        instr_valid;
   logic        busy;
   logic        overrun;
   logic        halt;

   int n_checks = 0;
   int n_fails  = 0;

   instr_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .pc            (pc),
      .pc_strobe     (pc_strobe),
      .prog_we       (prog_we),
      .prog_addr     (prog_addr),
      .prog_wdata    (prog_wdata),
      .instr_ready   (instr_ready),
      .clear_overrun (clear_overrun),
      .instr         (instr),
      .instr_addr    (instr_addr),
      .instr_valid   (instr_valid),
      .busy          (busy),
      .overrun       (overrun),
      .halt          (halt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] a, input logic [15:0] d);
      prog_we = 1'b1; prog_addr = a; prog_wdata = d;
      tick();
      prog_we = 1'b0;
   endtask

   // Strobe driven in the cycle after edge N, registered at N+1, valid after N+2.
   task automatic fetch_hold(input logic [7:0] a);
      instr_ready = 1'b0;
      pc = a; pc_strobe = 1'b1;
      tick();
      pc_strobe = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(); tick();
      n_checks++; if (instr_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
      n_checks++; if (instr !== 16'h0000) begin n_fails++; $display("FAIL reset_instr: got %h exp 0000", instr); end
      n_checks++; if (instr_addr !== 8'h00) begin n_fails++; $display("FAIL reset_addr: got %h exp 00", instr_addr); end
      n_checks++; if ({busy, overrun, halt} !== 3'b000) begin n_fails++; $display("FAIL reset_flags: got busy/ovr/halt=%b exp 000", {busy, overrun, halt}); end
      rst = 1'b1;
   endtask

   task automatic test_basic();
      load(8'h05, 16'h1234);
      instr_ready = 1'b1;
      pc = 8'h05; pc_strobe = 1'b1;
      tick();
      pc_strobe = 1'b0;
      n_checks++; if ({busy, instr_valid} !== 2'b10) begin n_fails++; $display("FAIL basic_read: got busy/valid=%b exp 10", {busy, instr_valid}); end
      tick();
      n_checks++; if (instr_valid !== 1'b1) begin n_fails++; $display("FAIL basic_valid: got %b exp 1", instr_valid); end
      n_checks++; if (instr !== 16'h1234) begin n_fails++; $display("FAIL basic_instr: got %h exp 1234", instr); end
      n_checks++; if (instr_addr !== 8'h05) begin n_fails++; $display("FAIL basic_addr: got %h exp 05", instr_addr); end
      n_checks++; if (overrun !== 1'b0) begin n_fails++; $display("FAIL basic_ovr: got %b exp 0", overrun); end
      tick();
      n_checks++; if ({busy, instr_valid} !== 2'b00) begin n_fails++; $display("FAIL basic_done: got busy/valid=%b exp 00", {busy, instr_valid}); end
      instr_ready = 1'b0;
   endtask

   task automatic test_overrun();
      load(8'h01, 16'h0101);
      load(8'h02, 16'h0202);
      load(8'h03, 16'h0303);
      fetch_hold(8'h03);
      n_checks++; if (instr !== 16'h0303) begin n_fails++; $display("FAIL ovr_first: got %h exp 0303", instr); end
      pc = 8'h01; pc_strobe = 1'b1;
      tick();
      n_checks++; if (overrun !== 1'b0) begin n_fails++; $display("FAIL ovr_pend_empty: got %b exp 0", overrun); end
      n_checks++; if ({instr_valid, instr} !== {1'b1, 16'h0303}) begin n_fails++; $display("FAIL ovr_hold_stable: got %b/%h exp 1/0303", instr_valid, instr); end
      pc = 8'h02;
      tick();
      pc_strobe = 1'b0;
      n_checks++; if (overrun !== 1'b1) begin n_fails++; $display("FAIL ovr_pend_full: got %b exp 1", overrun); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      n_checks++; if ({busy, instr_valid} !== 2'b10) begin n_fails++; $display("FAIL ovr_refetch_read: got busy/valid=%b exp 10", {busy, instr_valid}); end
      tick();
      n_checks++; if ({instr_addr, instr} !== {8'h02, 16'h0202}) begin n_fails++; $display("FAIL ovr_pending_addr: got %h/%h exp 02/0202", instr_addr, instr); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      n_checks++; if ({busy, instr_valid} !== 2'b00) begin n_fails++; $display("FAIL ovr_no_extra: got busy/valid=%b exp 00", {busy, instr_valid}); end
      clear_overrun = 1'b1;
      tick();
      clear_overrun = 1'b0;
      n_checks++; if (overrun !== 1'b0) begin n_fails++; $display("FAIL ovr_clear: got %b exp 0", overrun); end
   endtask

   task automatic test_rbw();
      load(8'h10, 16'h5555);
      instr_ready = 1'b0;
      pc = 8'h10; pc_strobe = 1'b1;
      tick();
      pc_strobe = 1'b0;
      prog_we = 1'b1; prog_addr = 8'h10; prog_wdata = 16'hAAAA;
      tick();
      prog_we = 1'b0;
      n_checks++; if (instr !== 16'h5555) begin n_fails++; $display("FAIL rbw_old: got %h exp 5555", instr); end
      instr_ready = 1'b1;
      tick();
      fetch_hold(8'h10);
      n_checks++; if (instr !== 16'hAAAA) begin n_fails++; $display("FAIL rbw_new: got %h exp AAAA", instr); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      load(8'h30, 16'h3030);
      load(8'h31, 16'h3131);
      fetch_hold(8'h30);
      n_checks++; if (instr !== 16'h3030) begin n_fails++; $display("FAIL b2b_first: got %h exp 3030", instr); end
      instr_ready = 1'b1; pc = 8'h31; pc_strobe = 1'b1;
      tick();
      instr_ready = 1'b0; pc_strobe = 1'b0;
      n_checks++; if ({busy, instr_valid} !== 2'b10) begin n_fails++; $display("FAIL b2b_gap: got busy/valid=%b exp 10", {busy, instr_valid}); end
      tick();
      n_checks++; if ({instr_valid, instr_addr, instr} !== {1'b1, 8'h31, 16'h3131}) begin n_fails++; $display("FAIL b2b_second: got %b/%h/%h exp 1/31/3131", instr_valid, instr_addr, instr); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
   endtask

   task automatic test_halt();
      load(8'h20, 16'hF000);
      fetch_hold(8'h20);
      n_checks++; if ({instr, halt} !== {16'hF000, 1'b0}) begin n_fails++; $display("FAIL halt_pre: got %h/%b exp F000/0", instr, halt); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      n_checks++; if ({halt, instr_valid, busy, overrun} !== 4'b1000) begin n_fails++; $display("FAIL halt_set: got halt/valid/busy/ovr=%b exp 1000", {halt, instr_valid, busy, overrun}); end
      pc = 8'h05; pc_strobe = 1'b1; clear_overrun = 1'b1;
      tick();
      pc_strobe = 1'b0; clear_overrun = 1'b0;
      n_checks++; if (overrun !== 1'b1) begin n_fails++; $display("FAIL halt_ovr_set_wins: got %b exp 1", overrun); end
      n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL halt_no_fetch: got busy=%b exp 0", busy); end
      tick(); tick();
      n_checks++; if ({instr_valid, halt} !== 2'b01) begin n_fails++; $display("FAIL halt_sticky: got valid/halt=%b exp 01", {instr_valid, halt}); end
   endtask

   task automatic test_reset_midfetch();
      rst = 1'b0;
      prog_we = 1'b1; prog_addr = 8'h40; prog_wdata = 16'h4444;
      tick();
      prog_we = 1'b0; rst = 1'b1;
      n_checks++; if ({halt, overrun} !== 2'b00) begin n_fails++; $display("FAIL rst_clears_halt: got halt/ovr=%b exp 00", {halt, overrun}); end
      fetch_hold(8'h05);
      pc = 8'h01; pc_strobe = 1'b1;
      tick(); tick();
      pc_strobe = 1'b0;
      n_checks++; if ({instr_valid, overrun} !== 2'b11) begin n_fails++; $display("FAIL rst_pre: got valid/ovr=%b exp 11", {instr_valid, overrun}); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      n_checks++; if ({instr_valid, busy, overrun, halt} !== 4'b0000) begin n_fails++; $display("FAIL rst_mid_flags: got valid/busy/ovr/halt=%b exp 0000", {instr_valid, busy, overrun, halt}); end
      n_checks++; if ({instr_addr, instr} !== {8'h00, 16'h0000}) begin n_fails++; $display("FAIL rst_mid_data: got %h/%h exp 00/0000", instr_addr, instr); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL rst_pending_cleared: got busy=%b exp 0", busy); end
      fetch_hold(8'h05);
      n_checks++; if (instr !== 16'h1234) begin n_fails++; $display("FAIL rst_mem_kept: got %h exp 1234", instr); end
      instr_ready = 1'b1;
      tick();
      fetch_hold(8'h40);
      n_checks++; if (instr !== 16'h4444) begin n_fails++; $display("FAIL rst_write_done: got %h exp 4444", instr); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b0; pc = 8'h00; pc_strobe = 1'b0;
      prog_we = 1'b0; prog_addr = 8'h00; prog_wdata = 16'h0000;
      instr_ready = 1'b0; clear_overrun = 1'b0;
      test_reset();
      test_basic();
      test_overrun();
      test_rbw();
      test_back_to_back();
      test_halt();
      test_reset_midfetch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
